// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Free-running up-counter with a power-of-two clock prescaler.
// The timer register block upstream uses it to refresh TDR0/TDR1 and to
// evaluate compare match. The counter advances by one on every prescaler
// tick. Load, restart, halt and disable controls can override that increment.
//
// Ports
//   sys_clk         clock
//   sys_rst_n       asynchronous active-low reset
//   timer_en        counting enable
//   div_en          prescaler enable
//   div_val         prescale exponent, tick period = 2^div_val cycles
//                   (values above MAX_DIV are treated as MAX_DIV)
//   cnt_tdr         load value
//   cnt_tdr_en      load strobe; wins over every other control
//   cnt_clr         compare-match pulse, restarts the prescaler phase
//   timer_en_nedge  timer_en falling-edge pulse, returns counter to 0
//   halt_en         debug halt, freezes counter and prescaler
//   count           registered counter value
//   cnt_update      registered one-cycle strobe, high while the freshly
//                   incremented count is visible on count
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int CNT_W   = 64,
    parameter int DIV_W   = 4,
    parameter int MAX_DIV = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] cnt_tdr,
    input  logic             cnt_tdr_en,
    input  logic             cnt_clr,
    input  logic             timer_en_nedge,
    input  logic             halt_en,
    output logic [CNT_W-1:0] count,
    output logic             cnt_update
);

    localparam logic [DIV_W-1:0] MAX_DIV_V = DIV_W'(MAX_DIV);

    logic [CNT_W-1:0]   count_q, count_d;
    logic               cnt_update_q, cnt_update_d;
    logic [MAX_DIV-1:0] pcnt_q, pcnt_d;

    logic [DIV_W-1:0]   div_eff;
    logic [MAX_DIV-1:0] pcnt_term;
    logic               tick;

    // Out-of-range exponents are clamped so the terminal count always fits
    // in the prescaler.
    assign div_eff = (div_val > MAX_DIV_V) ? MAX_DIV_V : div_val;

    // Terminal count (2^div_eff)-1 built as a thermometer mask. This avoids
    // a shift that would overflow the prescaler width when div_eff == MAX_DIV.
    for (genvar gi = 0; gi < MAX_DIV; gi++) begin : g_term
        assign pcnt_term[gi] = (DIV_W'(gi) < div_eff);
    end

    // An exact compare is used instead of a ">=" compare. When the period
    // shrinks while the prescaler is already past the new terminal count,
    // the prescaler runs on to its natural wrap before it ticks.
    assign tick = ~div_en | (div_eff == '0) | (pcnt_q == pcnt_term);

    always_comb begin
        count_d      = count_q;
        pcnt_d       = pcnt_q;
        cnt_update_d = 1'b0;
        if (cnt_tdr_en) begin
            count_d = cnt_tdr;
            pcnt_d  = '0;
        end else if (timer_en_nedge) begin
            count_d = '0;
            pcnt_d  = '0;
        end else if (halt_en) begin
            // Everything frozen. After release, the prescaler resumes from
            // the same phase.
            count_d = count_q;
        end else if (!timer_en) begin
            pcnt_d = '0;
        end else if (tick) begin
            // A tick also covers a coincident cnt_clr, because both
            // restart the prescaler phase.
            count_d      = count_q + CNT_W'(1);
            pcnt_d       = '0;
            cnt_update_d = 1'b1;
        end else if (cnt_clr) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + MAX_DIV'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q      <= '0;
            pcnt_q       <= '0;
            cnt_update_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            pcnt_q       <= pcnt_d;
            cnt_update_q <= cnt_update_d;
        end
    end

    assign count      = count_q;
    assign cnt_update = cnt_update_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        timer_en, div_en, cnt_tdr_en, cnt_clr, timer_en_nedge, halt_en;
    logic [3:0]  div_val;
    logic [63:0] cnt_tdr;
    logic [63:0] count;
    logic        cnt_update;

    int checks = 0;
    int errors = 0;

    timer_counter #(.CNT_W(64), .DIV_W(4), .MAX_DIV(8)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .timer_en       (timer_en),
        .div_en         (div_en),
        .div_val        (div_val),
        .cnt_tdr        (cnt_tdr),
        .cnt_tdr_en     (cnt_tdr_en),
        .cnt_clr        (cnt_clr),
        .timer_en_nedge (timer_en_nedge),
        .halt_en        (halt_en),
        .count          (count),
        .cnt_update     (cnt_update)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural reference model ----------------
    // The prescaler is modelled as "cycles elapsed in the current period".
    logic [63:0] m_count;
    int unsigned m_phase;
    bit          m_upd;

    function automatic void model_reset();
        m_count = 64'd0;
        m_phase = 0;
        m_upd   = 1'b0;
    endfunction

    function automatic void model_step();
        int unsigned eff;
        int unsigned period;
        bit          tk;
        eff    = (div_val > 4'd8) ? 8 : int'(div_val);
        period = 1 << eff;
        tk     = !div_en || (eff == 0) || (m_phase == period - 1);
        m_upd  = 1'b0;
        if (cnt_tdr_en) begin
            m_count = cnt_tdr; m_phase = 0;
        end else if (timer_en_nedge) begin
            m_count = 64'd0; m_phase = 0;
        end else if (halt_en) begin
            m_phase = m_phase;
        end else if (!timer_en) begin
            m_phase = 0;
        end else if (tk) begin
            m_count = m_count + 64'd1; m_phase = 0; m_upd = 1'b1;
        end else if (cnt_clr) begin
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % 256;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic drive(input logic en, input logic den, input logic [3:0] dval,
                         input logic [63:0] tdr, input logic tdr_en, input logic clr,
                         input logic nedge, input logic halt);
        timer_en = en; div_en = den; div_val = dval; cnt_tdr = tdr;
        cnt_tdr_en = tdr_en; cnt_clr = clr; timer_en_nedge = nedge; halt_en = halt;
    endtask

    // One clock: advance model with the inputs in effect, then sample after edge.
    task automatic step();
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic        den;
        logic [3:0]  dval;
        logic [63:0] tdr;
        logic        tdr_en;
        logic        clr;
        logic        nedge;
        logic        halt;
        logic [63:0] exp_cnt;
        logic        exp_upd;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int pulses;
        logic [63:0] base;
        logic [63:0] rtdr;

        // en den dval tdr tdr_en clr nedge halt exp_cnt exp_upd
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd0,     1'b1};
        vecs[3]  = '{1'b1, 1'b0, 4'd0, 64'h10,   1'b1, 1'b0, 1'b0, 1'b0, 64'h10,    1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd0, 64'h55,   1'b1, 1'b0, 1'b1, 1'b0, 64'h55,    1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd0, 64'h55,   1'b0, 1'b0, 1'b1, 1'b0, 64'd0,     1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd0,     1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b1, 64'd0,     1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd1,     1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'd1, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd1,     1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'd1, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd2,     1'b1};
        vecs[11] = '{1'b1, 1'b1, 4'd9, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd2,     1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b1, 1'b0, 1'b0, 64'd3,     1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'd3,     1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'd0, 64'd0,    1'b0, 1'b0, 1'b1, 1'b1, 64'd0,     1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'd0, 64'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 64'hABCD,  1'b0};

        // ---- reset state ----
        sys_rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_count", count, 64'd0);
        check("reset_upd", {63'd0, cnt_update}, 64'd0);
        do_reset();
        check("post_reset_count", count, 64'd0);

        // ---- every-cycle counting ----
        drive(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("t1_count_c%0d", c), count, 64'(c));
            check($sformatf("t1_upd_c%0d", c), {63'd0, cnt_update}, 64'd1);
        end

        // ---- divide by 8 ----
        drive(1'b1, 1'b1, 4'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (cnt_update) pulses++;
            check($sformatf("t2_count_c%0d", c), count, 64'(5 + c / 8));
            check($sformatf("t2_upd_c%0d", c), {63'd0, cnt_update}, 64'((c % 8) == 0));
        end
        check("t2_pulse_total", 64'(pulses), 64'd3);

        // ---- table vectors ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].den, vecs[i].dval, vecs[i].tdr,
                  vecs[i].tdr_en, vecs[i].clr, vecs[i].nedge, vecs[i].halt);
            step();
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_upd", i), {63'd0, cnt_update}, {63'd0, vecs[i].exp_upd});
        end

        // ---- halt keeps prescaler phase ----
        drive(1'b1, 1'b1, 4'd2, 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("t4_load", count, 64'h100);
        drive(1'b1, 1'b1, 4'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        check("t4_pre_halt", count, 64'h100);
        drive(1'b1, 1'b1, 4'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("t4_halt_c%0d", c), count, 64'h100);
            check($sformatf("t4_halt_upd_c%0d", c), {63'd0, cnt_update}, 64'd0);
        end
        drive(1'b1, 1'b1, 4'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("t4_rel1", count, 64'h100);
        step();
        check("t4_rel2", count, 64'h101);
        check("t4_rel2_upd", {63'd0, cnt_update}, 64'd1);
        repeat (3) step();
        check("t4_rel5", count, 64'h101);
        step();
        check("t4_rel6", count, 64'h102);

        // ---- cnt_clr restarts the period at pcnt=7 ----
        drive(1'b1, 1'b1, 4'd4, 64'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 4'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step();
        check("t6_pre_clr", count, 64'h200);
        drive(1'b1, 1'b1, 4'd4, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("t6_clr_upd", {63'd0, cnt_update}, 64'd0);
        drive(1'b1, 1'b1, 4'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) step();
        check("t6_c15", count, 64'h200);
        step();
        check("t6_c16", count, 64'h201);
        check("t6_c16_upd", {63'd0, cnt_update}, 64'd1);

        // ---- async reset mid-run ----
        drive(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("t6_run", count, 64'h204);
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_count", count, 64'd0);
        check("t6_async_upd", {63'd0, cnt_update}, 64'd0);
        @(negedge sys_clk);
        drive(1'b1, 1'b1, 4'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        repeat (3) step();
        check("t6_resume3", count, 64'd0);
        step();
        check("t6_resume4", count, 64'd1);

        // ---- randomized run against the model ----
        do_reset();
        drive(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                div_en  = $urandom_range(0, 3) != 0;
                div_val = 4'($urandom_range(0, 10));
            end
            timer_en       = $urandom_range(0, 15) != 0;
            cnt_tdr_en     = $urandom_range(0, 31) == 0;
            timer_en_nedge = $urandom_range(0, 47) == 0;
            halt_en        = $urandom_range(0, 9) == 0;
            cnt_clr        = $urandom_range(0, 15) == 0;
            rtdr = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) rtdr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(rtdr[3:0]);
            cnt_tdr = rtdr;
            step();
            check($sformatf("rnd%0d_count", n), count, m_count);
            check($sformatf("rnd%0d_upd", n), {63'd0, cnt_update}, {63'd0, m_upd});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
